// File: rtl/core_pipe_exec_muldiv.sv
// Iterative integer multiply/divide unit: shift-add multiplier and restoring divider
// sharing one IDLE -> MUL|DIV -> DONE -> IDLE controller with a one-cycle result pulse.
module core_pipe_exec_muldiv #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 4,
  parameter int DIV_UNROLL = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  // valid/ready: a request is accepted on the edge where valid=1 in IDLE (flush=0);
  // the requester holds valid, opcode and operands stable until ready, which pulses
  // for exactly one cycle with rd; rd is 0 whenever ready is 0.
  input  logic            valid,
  input  logic            op_word,
  input  logic            op_mul,
  input  logic            op_mulh,
  input  logic            op_mulhu,
  input  logic            op_mulhsu,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_rem,
  input  logic            op_remu,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic [XLEN-1:0] rd,
  output logic [1:0]      dbg_state
);

  localparam int CW = 7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
  state_t state_q, state_d;

  // Request decode, evaluated only on the accepting edge.
  logic            word, sgn1, sgn2, neg1, neg2, is_div, is_rem, div_zero, div_ovf, special, start;
  logic [XLEN-1:0] wmask, s1x, s2x, mag1, mag2, min_mag, special_res;
  logic [CW-1:0]   iter_init;

  assign word    = (XLEN == 64) && op_word;
  assign sgn1    = op_mul | op_mulh | op_mulhsu | op_div | op_rem;
  assign sgn2    = op_mul | op_mulh | op_div | op_rem;
  assign is_div  = op_div | op_divu | op_rem | op_remu;
  assign is_rem  = op_rem | op_remu;
  assign wmask   = word ? XLEN'(32'hFFFF_FFFF) : '1;
  assign s1x     = word ? XLEN'($signed(rs1[31:0])) : rs1;
  assign s2x     = word ? XLEN'($signed(rs2[31:0])) : rs2;
  assign neg1    = sgn1 & s1x[XLEN-1];
  assign neg2    = sgn2 & s2x[XLEN-1];
  assign mag1    = (neg1 ? -s1x : s1x) & wmask;
  assign mag2    = (neg2 ? -s2x : s2x) & wmask;
  assign min_mag = word ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (mag2 == '0);
  assign div_ovf  = (op_div | op_rem) & neg1 & neg2 & (mag1 == min_mag) & (mag2 == XLEN'(1));
  assign special  = is_div & (div_zero | div_ovf);
  // s1x is already the sign-extended W-bit dividend, which both special cases return.
  assign special_res = div_zero ? (is_rem ? s1x : '1) : (is_rem ? '0 : s1x);
  assign iter_init = is_div ? (word ? CW'(32 / DIV_UNROLL) : CW'(XLEN / DIV_UNROLL))
                            : (word ? CW'(32 / MUL_UNROLL) : CW'(XLEN / MUL_UNROLL));
  assign start = (state_q == S_IDLE) & valid & ~flush;

  // Latched operation and iteration state.
  logic              word_q, hi_q, rem_q, neg_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] mcand_q, acc_q;
  logic [XLEN-1:0]   mplier_q, quo_q, dvsr_q, rd_q;
  logic [XLEN:0]     prem_q;

  logic [2*XLEN-1:0] m_acc, m_cand, p;
  logic [XLEN-1:0]   m_plier, d_q, qv, rv, dv, mul_res, div_res, rd_d;
  logic [XLEN:0]     d_r;

  // One cycle worth of shift-add and restoring-division steps.
  always_comb begin
    m_acc   = acc_q;
    m_cand  = mcand_q;
    m_plier = mplier_q;
    for (int i = 0; i < MUL_UNROLL; i++) begin
      if (m_plier[0]) m_acc = m_acc + m_cand;
      m_cand  = m_cand << 1;
      m_plier = m_plier >> 1;
    end
    d_q = quo_q;
    d_r = prem_q;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      d_r = {d_r[XLEN-1:0], d_q[XLEN-1]};
      d_q = d_q << 1;
      if (d_r >= {1'b0, dvsr_q}) begin
        d_r    = d_r - {1'b0, dvsr_q};
        d_q[0] = 1'b1;
      end
    end
  end

  // Sign correction and result selection from the final-step values.
  always_comb begin
    p       = neg_q ? -m_acc : m_acc;
    mul_res = hi_q ? (word_q ? XLEN'($signed(p[63:32])) : p[2*XLEN-1:XLEN])
                   : (word_q ? XLEN'($signed(p[31:0]))  : p[XLEN-1:0]);
    qv      = neg_q ? -d_q : d_q;
    rv      = neg_q ? -d_r[XLEN-1:0] : d_r[XLEN-1:0];
    dv      = rem_q ? rv : qv;
    div_res = word_q ? XLEN'($signed(dv[31:0])) : dv;
  end

  always_comb begin
    state_d = state_q;
    rd_d    = '0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (valid) begin
          if (special) begin
            state_d = S_DONE;
            rd_d    = special_res;
          end else if (is_div) begin
            state_d = S_DIV;
          end else begin
            state_d = S_MUL;
          end
        end
        S_MUL: if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          rd_d    = mul_res;
        end
        S_DIV: if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          rd_d    = div_res;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      word_q   <= 1'b0;
      hi_q     <= 1'b0;
      rem_q    <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      prem_q   <= '0;
    end else if (start) begin
      word_q   <= word;
      hi_q     <= op_mulh | op_mulhu | op_mulhsu;
      rem_q    <= is_rem;
      neg_q    <= is_rem ? neg1 : (neg1 ^ neg2);
      cnt_q    <= iter_init;
      mcand_q  <= (2*XLEN)'(mag1);
      acc_q    <= '0;
      mplier_q <= mag2;
      // Word dividends are left-aligned so the divider always shifts out from the MSB.
      quo_q    <= word ? (mag1 << (XLEN - 32)) : mag1;
      dvsr_q   <= mag2;
      prem_q   <= '0;
    end else if (state_q == S_MUL) begin
      acc_q    <= m_acc;
      mcand_q  <= m_cand;
      mplier_q <= m_plier;
      cnt_q    <= cnt_q - CW'(1);
    end else if (state_q == S_DIV) begin
      quo_q    <= d_q;
      prem_q   <= d_r;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  assign ready     = (state_q == S_DONE);
  assign rd        = rd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_core_pipe_exec_muldiv.sv
// Bench for core_pipe_exec_muldiv (XLEN=64, MUL_UNROLL=4, DIV_UNROLL=1): directed vector
// table, multi-cycle corner sequences, and random ops checked against an arithmetic model.
module tb_core_pipe_exec_muldiv;

  logic        g_clk, g_resetn, flush, valid, op_word;
  logic        op_mul, op_mulh, op_mulhu, op_mulhsu, op_div, op_divu, op_rem, op_remu;
  logic [63:0] rs1, rs2, rd;
  logic        ready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  core_pipe_exec_muldiv #(.XLEN(64), .MUL_UNROLL(4), .DIV_UNROLL(1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .valid(valid), .op_word(op_word),
    .op_mul(op_mul), .op_mulh(op_mulh), .op_mulhu(op_mulhu), .op_mulhsu(op_mulhsu),
    .op_div(op_div), .op_divu(op_divu), .op_rem(op_rem), .op_remu(op_remu),
    .rs1(rs1), .rs2(rs2), .ready(ready), .rd(rd), .dbg_state(dbg_state)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Opcode index: 0 mul, 1 mulh, 2 mulhu, 3 mulhsu, 4 div, 5 divu, 6 rem, 7 remu.
  typedef struct {
    int          op;
    bit          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] model(input int op, input bit w, input logic [63:0] a,
                                        input logic [63:0] b, output int lat);
    logic [127:0] ea, eb, prod;
    logic [31:0]  x32, y32, r32;
    logic [63:0]  r64;
    bit s1, s2, sg, rm;
    if (op < 4) begin
      s1 = (op == 0) || (op == 1) || (op == 3);
      s2 = (op == 0) || (op == 1);
      if (w) begin
        ea   = s1 ? {{96{a[31]}}, a[31:0]} : {96'd0, a[31:0]};
        eb   = s2 ? {{96{b[31]}}, b[31:0]} : {96'd0, b[31:0]};
        prod = ea * eb;
        lat  = 32 / 4 + 1;
        return (op == 0) ? sx32(prod[31:0]) : sx32(prod[63:32]);
      end
      ea   = s1 ? {{64{a[63]}}, a} : {64'd0, a};
      eb   = s2 ? {{64{b[63]}}, b} : {64'd0, b};
      prod = ea * eb;
      lat  = 64 / 4 + 1;
      return (op == 0) ? prod[63:0] : prod[127:64];
    end
    sg = (op == 4) || (op == 6);
    rm = (op == 6) || (op == 7);
    if (w) begin
      x32 = a[31:0];
      y32 = b[31:0];
      if (y32 == 0) begin
        lat = 1; r32 = rm ? x32 : 32'hFFFF_FFFF;
      end else if (sg && x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) begin
        lat = 1; r32 = rm ? 32'd0 : x32;
      end else begin
        lat = 33;
        if (sg) r32 = rm ? $signed(x32) % $signed(y32) : $signed(x32) / $signed(y32);
        else    r32 = rm ? x32 % y32 : x32 / y32;
      end
      return sx32(r32);
    end
    if (b == 0) begin
      lat = 1; r64 = rm ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      lat = 1; r64 = rm ? 64'd0 : a;
    end else begin
      lat = 65;
      if (sg) r64 = rm ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      else    r64 = rm ? a % b : a / b;
    end
    return r64;
  endfunction

  task automatic clear_ops();
    valid = 0; op_word = 0;
    op_mul = 0; op_mulh = 0; op_mulhu = 0; op_mulhsu = 0;
    op_div = 0; op_divu = 0; op_rem = 0; op_remu = 0;
  endtask

  task automatic set_op(input int op, input bit w, input logic [63:0] a, input logic [63:0] b);
    clear_ops();
    op_mul = (op == 0); op_mulh = (op == 1); op_mulhu = (op == 2); op_mulhsu = (op == 3);
    op_div = (op == 4); op_divu = (op == 5); op_rem = (op == 6); op_remu = (op == 7);
    op_word = w; rs1 = a; rs2 = b; valid = 1;
  endtask

  // Cycle c=1 is the cycle right after the accepting edge T; ready at T+lat means c==lat.
  task automatic wait_result(input string name, input logic [63:0] exp, input int exp_lat);
    int got;
    logic early;
    logic [63:0] res;
    got = 0; early = 0; res = '0;
    @(posedge g_clk);
    for (int c = 1; c <= 200; c++) begin
      #1;
      if (ready) begin
        got = c; res = rd;
        break;
      end
      if (rd !== 64'd0) early = 1;
      @(posedge g_clk);
    end
    clear_ops();
    if (got == 0) $display("FAIL %s_timeout: got no ready expected ready within 200 cycles", name);
    check({name, "_lat"}, 64'(got), 64'(exp_lat));
    check({name, "_rd"}, res, exp);
    check({name, "_rd_zero_before"}, {63'd0, early}, 64'd0);
    @(posedge g_clk);
    #1;
    check({name, "_pulse_end"}, {ready, rd[62:0]} | {1'b0, rd[63], 62'd0}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, c1, c2;
    logic [63:0] exp, a, b, r1, r2;
    int op;
    bit w;

    tbl[0]  = '{0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 17};
    tbl[1]  = '{3, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 17};
    tbl[2]  = '{4, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    tbl[3]  = '{6, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1};
    tbl[4]  = '{5, 0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[5]  = '{6, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    tbl[6]  = '{7, 0, 64'd10, 64'd3, 64'd1, 65};
    tbl[7]  = '{2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 17};
    tbl[8]  = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 17};
    tbl[9]  = '{4, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    tbl[10] = '{0, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 9};
    tbl[11] = '{5, 1, 64'h1234_5678_FFFF_FFFF, 64'h10, 64'h0000_0000_0FFF_FFFF, 33};
    tbl[12] = '{6, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    tbl[13] = '{7, 1, 64'hAAAA_AAAA_8000_0001, 64'h5555_5555_0000_0000, 64'hFFFF_FFFF_8000_0001, 1};
    tbl[14] = '{4, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    tbl[15] = '{1, 0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 17};

    // Clock/reset
    g_resetn = 0; flush = 0; rs1 = '0; rs2 = '0;
    clear_ops();
    #3;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_rd", rd, 64'd0);
    repeat (2) @(negedge g_clk);
    g_resetn = 1;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      set_op(tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b);
      wait_result($sformatf("vec%0d", i), tbl[i].exp, tbl[i].lat);
    end

    // valid held across DONE starts a second operation in the following IDLE cycle
    set_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    c1 = 0; c2 = 0; r1 = '0; r2 = '0;
    @(posedge g_clk);
    for (int c = 1; c <= 100 && c2 == 0; c++) begin
      #1;
      if (ready) begin
        if (c1 == 0) begin
          c1 = c; r1 = rd;
        end else begin
          c2 = c; r2 = rd; clear_ops();
        end
      end
      @(posedge g_clk);
    end
    #1;
    check("b2b_lat1", 64'(c1), 64'd17);
    check("b2b_lat2", 64'(c2), 64'd35);
    check("b2b_rd1", r1, 64'hFFFF_FFFF_FFFF_FFFD);
    check("b2b_rd2", r2, 64'hFFFF_FFFF_FFFF_FFFD);
    check("b2b_idle_after", {63'd0, ready}, 64'd0);

    // Flush mid-DIV at T+10, new mul accepted at T+12
    set_op(4, 0, 64'd1000, 64'd7);
    @(posedge g_clk);
    repeat (9) @(posedge g_clk);
    #1;
    flush = 1;
    clear_ops();
    @(posedge g_clk);
    #1;
    check("flush_ready", {63'd0, ready}, 64'd0);
    check("flush_rd", rd, 64'd0);
    flush = 0;
    @(posedge g_clk);
    #1;
    check("flush_ready_next", {63'd0, ready}, 64'd0);
    set_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    wait_result("post_flush_mul", 64'hFFFF_FFFF_FFFF_FFFD, 17);

    // Reset asserted during DONE clears ready and rd without a clock edge
    set_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    @(posedge g_clk);
    repeat (16) @(posedge g_clk);
    #1;
    check("pre_reset_ready", {63'd0, ready}, 64'd1);
    check("pre_reset_rd", rd, 64'hFFFF_FFFF_FFFF_FFFD);
    #2;
    g_resetn = 0;
    #1;
    check("reset_async_ready", {63'd0, ready}, 64'd0);
    check("reset_async_rd", rd, 64'd0);
    clear_ops();
    @(negedge g_clk);
    g_resetn = 1;

    // Reset mid-DIV discards the operation; next op starts fresh
    set_op(4, 0, 64'd12345, 64'd17);
    @(posedge g_clk);
    repeat (5) @(posedge g_clk);
    #3;
    g_resetn = 0;
    #1;
    check("reset_middiv_ready", {63'd0, ready}, 64'd0);
    check("reset_middiv_rd", rd, 64'd0);
    clear_ops();
    @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1;
    set_op(7, 0, 64'd10, 64'd3);
    wait_result("post_reset_remu", 64'd1, 65);

    // Random operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7);
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: b = w ? {b[63:32], 32'd0} : 64'd0;
        1: b = 64'($urandom_range(1, 20));
        2: begin
          a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {b[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        default: ;
      endcase
      exp = model(op, w, a, b, lat);
      set_op(op, w, a, b);
      wait_result($sformatf("rand%0d_op%0d_w%0d", n, op, w), exp, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_pipe_exec_muldiv.md
CORE_PIPE_EXEC_MULDIV -- requirements
Module: core_pipe_exec_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter MUL_UNROLL, default 4: multiplier bits retired per cycle; legal values 1, 2, 4 or 8.
REQ-003 SHALL have parameter DIV_UNROLL, default 1: quotient bits retired per cycle; legal values 1 or 2.
REQ-004 g_clk  in  1  clock; single clock domain.
REQ-005 g_resetn  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  abandon the current operation.
REQ-007 valid  in  1  request; held high with stable operands and opcode until ready.
REQ-008 op_word  in  1  32-bit word operation; legal only when XLEN=64.
REQ-009 op_mul, op_mulh, op_mulhu, op_mulhsu, op_div, op_divu, op_rem, op_remu  in  1 each  opcode, one-hot while valid.
REQ-010 rs1, rs2  in  XLEN  source operands.
REQ-011 ready  out  1  one-cycle completion pulse.
REQ-012 rd  out  XLEN  result; valid only while ready=1.

Function
REQ-013 SHALL implement the FSM IDLE -> MUL | DIV -> DONE -> IDLE.
REQ-014 IDLE, with valid=1 and flush=0 at edge T: latch operands and opcode; go to MUL or DIV. Latched values are used thereafter; inputs are not re-sampled.
REQ-015 Operand width W = 32 if op_word, else XLEN.
- Word ops use rs1[31:0] and rs2[31:0].
- The result is sign-extended from bit 31 to XLEN.
REQ-016 Signedness:
- Signed operands are converted to magnitude at latch time; the sign is corrected at DONE.
- mul, mulh, div, rem: both operands signed.
- mulhsu: rs1 signed, rs2 unsigned.
- mulhu, divu, remu: both operands unsigned.
REQ-017 MUL runs a shift-add over a 2W-bit product for W/MUL_UNROLL cycles.
- mul returns product[W-1:0].
- mulh, mulhu, mulhsu return product[2W-1:W].
REQ-018 DIV runs a restoring division for W/DIV_UNROLL cycles.
- Quotient sign = sign(rs1) XOR sign(rs2).
- Remainder sign = sign(rs1).
REQ-019 Divide by zero completes with no iteration: IDLE -> DONE directly.
- div/divu return all-ones (at width W, then sign-extended).
- rem/remu return the W-bit dividend (sign-extended for word ops).
REQ-020 Signed overflow (dividend = -2^(W-1), divisor = -1) completes with no iteration: IDLE -> DONE directly.
- div returns the dividend.
- rem returns 0.
REQ-021 DONE: ready=1 and rd = registered final result for exactly one cycle, then IDLE.
REQ-022 Latency from valid at T to ready:
- MUL: T + W/MUL_UNROLL + 1.
- DIV: T + W/DIV_UNROLL + 1.
- Special cases (REQ-019, REQ-020): T + 1.
REQ-023 valid still high in the IDLE cycle after DONE SHALL start a new operation; the requester drops valid after ready.
REQ-024 flush=1 at any edge SHALL force IDLE and ready=0 on the next cycle.
- flush has priority over valid and over FSM progress.
- No result from the abandoned operation is ever presented.
REQ-025 ready SHALL never be high outside DONE.
REQ-026 rd SHALL be 0 outside DONE.
REQ-027 Operation in the MUL/DIV cycle count is fixed; there is no early termination except REQ-019 and REQ-020.

Reset
REQ-028 g_resetn=0 SHALL immediately, without waiting for a clock edge, force:
- FSM = IDLE, ready=0, rd=0;
- counters, operand registers and accumulators = 0.
REQ-029 Reset asserted mid-operation SHALL discard that operation; the first valid after reset release starts a fresh operation.

Verification
REQ-030 XLEN=64, MUL_UNROLL=4, op_mul, rs1=0xFFFFFFFFFFFFFFFF (-1), rs2=3, valid at T -> ready at T+17, rd=0xFFFFFFFFFFFFFFFD.
REQ-031 op_mulhsu, rs1=-2, rs2=0xFFFFFFFFFFFFFFFF -> rd=0xFFFFFFFFFFFFFFFE.
REQ-032 op_div, op_word, rs1=0x80000000, rs2=0xFFFFFFFF -> ready at T+1, rd=0xFFFFFFFF80000000.
- Repeat with op_rem -> rd=0.
REQ-033 op_divu, rs1=7, rs2=0 -> ready at T+1, rd=all-ones.
- op_rem, rs1=-7, rs2=2, DIV_UNROLL=1 -> ready at T+65, rd=0xFFFFFFFFFFFFFFFF (-1).
REQ-034 op_div started, flush at T+10 -> ready stays 0; a new op_mul valid at T+12 -> correct result at T+12+17.
REQ-035 g_resetn pulsed low mid-DIV between edges -> ready and rd are 0 immediately.
- The next op_remu, rs1=10, rs2=3 -> rd=1 at the expected latency.
